even_odd_classifier: RTL and testbench

EVEN_ODD_CLASSIFIER -- requirements
Module: even_odd_classifier

---
 rtl/even_odd_classifier.sv | 95 +++++++++
 tb/tb_even_odd_classifier.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_odd_classifier.sv
// Classifies each accepted word as even or odd (by LSB or by parity of all bits),
// holds the result behind a valid/ready handshake and keeps saturating class counters.
module even_odd_classifier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             even,
  output logic             odd,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Mode 0 looks only at the LSB; mode 1 uses the parity of the whole word.
  function automatic logic classify_odd(input logic [WIDTH-1:0] d, input logic m);
    return m ? ^d : d[0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic             accept_p0;
  logic             odd_p0;
  logic             vld_p1;
  logic             even_p1;
  logic             odd_p1;
  logic [CNT_W-1:0] even_cnt_p1;
  logic [CNT_W-1:0] odd_cnt_p1;
  logic             sat_p1;
  logic [CNT_W-1:0] even_cnt_nxt;
  logic [CNT_W-1:0] odd_cnt_nxt;
  logic             sat_nxt;

  // Stage p0: handshake and classification of the incoming word
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign odd_p0    = classify_odd(data_in, mode);

  // Clear happens first so a coincident accept lands on a zeroed counter.
  always_comb begin
    even_cnt_nxt = clr_cnt ? '0 : even_cnt_p1;
    odd_cnt_nxt  = clr_cnt ? '0 : odd_cnt_p1;
    if (accept_p0) begin
      if (odd_p0) odd_cnt_nxt  = sat_inc(odd_cnt_nxt);
      else        even_cnt_nxt = sat_inc(even_cnt_nxt);
    end
    sat_nxt = (sat_p1 && !clr_cnt) || (even_cnt_nxt == CNT_MAX) || (odd_cnt_nxt == CNT_MAX);
  end

  // Stage p1: held result and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      even_p1     <= 1'b0;
      odd_p1      <= 1'b0;
      even_cnt_p1 <= '0;
      odd_cnt_p1  <= '0;
      sat_p1      <= 1'b0;
    end else begin
      if (accept_p0) begin
        vld_p1  <= 1'b1;
        even_p1 <= !odd_p0;
        odd_p1  <= odd_p0;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
        even_p1 <= 1'b0;
        odd_p1  <= 1'b0;
      end
      even_cnt_p1 <= even_cnt_nxt;
      odd_cnt_p1  <= odd_cnt_nxt;
      sat_p1      <= sat_nxt;
    end
  end

  assign out_valid = vld_p1;
  assign even      = even_p1;
  assign odd       = odd_p1;
  assign even_cnt  = even_cnt_p1;
  assign odd_cnt   = odd_cnt_p1;
  assign sat       = sat_p1;

endmodule

// File: tb/tb_even_odd_classifier.sv
// Bench for even_odd_classifier: three instances (16-bit counters, 2-bit counters,
// 1-bit word) share one stimulus stream and are compared with a word-level model.
module tb_even_odd_classifier;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] data_in;
  logic       mode;
  logic       out_ready;
  logic       clr_cnt;
  logic [0:0] w_data;

  logic        in_ready, out_valid, even, odd, sat;
  logic [15:0] even_cnt, odd_cnt;
  logic        s_in_ready, s_out_valid, s_even, s_odd, s_sat;
  logic [1:0]  s_even_cnt, s_odd_cnt;
  logic        w_in_ready, w_out_valid, w_even, w_odd, w_sat;
  logic [15:0] w_even_cnt, w_odd_cnt;

  assign w_data = data_in[0];

  even_odd_classifier #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .even(even), .odd(odd), .clr_cnt(clr_cnt), .even_cnt(even_cnt),
    .odd_cnt(odd_cnt), .sat(sat));

  even_odd_classifier #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .data_in(data_in), .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
    .even(s_even), .odd(s_odd), .clr_cnt(clr_cnt), .even_cnt(s_even_cnt),
    .odd_cnt(s_odd_cnt), .sat(s_sat));

  even_odd_classifier #(.WIDTH(1), .CNT_W(16)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .data_in(w_data), .mode(mode), .out_valid(w_out_valid), .out_ready(out_ready),
    .even(w_even), .odd(w_odd), .clr_cnt(clr_cnt), .even_cnt(w_even_cnt),
    .odd_cnt(w_odd_cnt), .sat(w_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: whether a result is held, its class, and how many words of each
  // class were accepted since the last clear (unbounded; clamped on compare).
  bit m_vld;
  bit m_odd;
  bit m_w1_odd;
  int m_ne;
  int m_no;

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_odd = 0; m_w1_odd = 0; m_ne = 0; m_no = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit cls_odd;
    acc = in_valid && (!m_vld || out_ready);
    if (clr_cnt) begin
      m_ne = 0;
      m_no = 0;
    end
    if (acc) begin
      cls_odd  = mode ? ($countones(data_in) % 2 == 1) : (data_in % 2 == 1);
      m_vld    = 1;
      m_odd    = cls_odd;
      m_w1_odd = data_in[0];
      if (cls_odd) m_no++;
      else         m_ne++;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end
  endtask

  function automatic logic [44:0] obs_vec();
    return {out_valid, even, odd, even_cnt, odd_cnt, sat, in_ready,
            s_out_valid, s_even, s_odd, s_even_cnt, s_odd_cnt, s_sat};
  endfunction

  function automatic logic [44:0] exp_vec();
    logic [15:0] ec, oc;
    logic [1:0]  sec, soc;
    ec  = 16'(clamp(m_ne, 65535));
    oc  = 16'(clamp(m_no, 65535));
    sec = 2'(clamp(m_ne, 3));
    soc = 2'(clamp(m_no, 3));
    return {m_vld, m_vld && !m_odd, m_vld && m_odd, ec, oc,
            (m_ne >= 65535 || m_no >= 65535), (!m_vld || out_ready),
            m_vld, m_vld && !m_odd, m_vld && m_odd, sec, soc,
            (m_ne >= 3 || m_no >= 3)};
  endfunction

  task automatic drive(input bit v, input logic [7:0] d, input bit md, input bit ordy, input bit clr);
    in_valid = v; data_in = d; mode = md; out_ready = ordy; clr_cnt = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 0, 0, 0);
    reset = 0;
    #1 reset = 1;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_async: got %h want %h", obs_vec(), exp_vec());
    end
    drive(1, 8'h01, 0, 0, 0);
    tick();
    tick();
    total++;
    if (obs_vec() !== exp_vec() || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_held: got %h want %h", obs_vec(), exp_vec());
    end
    drive(0, 8'h00, 0, 1, 0);
    reset = 0;
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stream();
    logic [7:0] words [3] = '{8'h02, 8'h03, 8'h80};
    logic [1:0] cls   [3] = '{2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      drive(1, words[i], 0, 1, 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || {out_valid, even, odd} !== {1'b1, cls[i]}) begin
        bad++; $display("FAIL stream_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    drive(0, 8'h00, 0, 1, 0);
    tick();
    total++;
    if (obs_vec() !== exp_vec() || even_cnt !== 16'd2 || odd_cnt !== 16'd1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_counts: got even=%0d odd=%0d vld=%b want 2 1 0", even_cnt, odd_cnt, out_valid);
    end
  endtask

  task automatic test_mode();
    logic [7:0] words [3] = '{8'h03, 8'h07, 8'h07};
    bit         md    [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] cls   [3] = '{2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 3; i++) begin
      drive(1, words[i], md[i], 1, 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || {even, odd} !== cls[i]) begin
        bad++; $display("FAIL mode_%0d: got %b%b want %b", i, even, odd, cls[i]);
      end
    end
    // Hold a mode-1 even result for 0x03, then flip mode while it is held.
    drive(1, 8'h03, 1, 1, 0);
    tick();
    drive(0, 8'h03, 1, 0, 0);
    tick();
    drive(0, 8'h03, 0, 0, 0);
    tick();
    total++;
    if (obs_vec() !== exp_vec() || {out_valid, even, odd} !== 3'b110) begin
      bad++; $display("FAIL mode_change_held: got %b%b%b want 110", out_valid, even, odd);
    end
    drive(0, 8'h00, 0, 1, 0);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1, 8'h04, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h05, 0, 0, 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || in_ready !== 1'b0 || {out_valid, even, odd} !== 3'b110) begin
        bad++; $display("FAIL backpressure_%0d: got rdy=%b res=%b%b%b want 0 110", i, in_ready, out_valid, even, odd);
      end
    end
    drive(1, 8'h05, 0, 1, 0);
    tick();
    total++;
    if (obs_vec() !== exp_vec() || {out_valid, even, odd} !== 3'b101) begin
      bad++; $display("FAIL backpressure_release: got %h want %h", obs_vec(), exp_vec());
    end
    drive(0, 8'h00, 0, 1, 0);
    tick();
  endtask

  task automatic test_saturation();
    int seq [5] = '{1, 2, 3, 3, 3};
    drive(0, 8'h00, 0, 1, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom_range(0, 127) * 2), 0, 1, 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || s_even_cnt !== 2'(seq[i]) || s_sat !== (seq[i] == 3)) begin
        bad++; $display("FAIL saturation_%0d: got cnt=%0d sat=%b want %0d %b", i, s_even_cnt, s_sat, seq[i], seq[i] == 3);
      end
    end
    drive(0, 8'h00, 0, 1, 1);
    tick();
    total++;
    if (obs_vec() !== exp_vec() || {s_even_cnt, s_odd_cnt, s_sat} !== 5'b0) begin
      bad++; $display("FAIL saturation_clear: got %0d %0d %b want 0 0 0", s_even_cnt, s_odd_cnt, s_sat);
    end
  endtask

  task automatic test_clr_accept();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h11, 0, 1, 0);
      tick();
    end
    total++;
    if (obs_vec() !== exp_vec() || s_sat !== 1'b1) begin
      bad++; $display("FAIL clr_accept_pre: got sat=%b want 1", s_sat);
    end
    drive(1, 8'h01, 0, 1, 1);
    tick();
    total++;
    if (obs_vec() !== exp_vec() || odd_cnt !== 16'd1 || even_cnt !== 16'd0 ||
        {s_odd_cnt, s_even_cnt, s_sat} !== 5'b01000 || sat !== 1'b0) begin
      bad++; $display("FAIL clr_accept: got odd=%0d even=%0d sat=%b want 1 0 0", s_odd_cnt, s_even_cnt, s_sat);
    end
    drive(0, 8'h00, 0, 1, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_width1();
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'($urandom), 1'($urandom), 1'($urandom), 0);
      tick();
      total++;
      if ({w_out_valid, w_even, w_odd} !== {m_vld, m_vld && !m_w1_odd, m_vld && m_w1_odd}) begin
        bad++; $display("FAIL width1_%0d: got %b%b%b want %b%b%b", i, w_out_valid, w_even, w_odd,
                        m_vld, m_vld && !m_w1_odd, m_vld && m_w1_odd);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 8'h00, 0, 1, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(2 * i + 1), 0, 1, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    tick();
    total++;
    if (obs_vec() !== exp_vec() || odd_cnt !== 16'd5 || out_valid !== 1'b1) begin
      bad++; $display("FAIL async_pre: got odd=%0d vld=%b want 5 1", odd_cnt, out_valid);
    end
    #2 reset = 1;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== exp_vec() || in_ready !== 1'b1 ||
        {out_valid, even, odd, even_cnt, odd_cnt, sat} !== 36'b0) begin
      bad++; $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    drive(1, 8'h01, 0, 1, 0);
    #2 reset = 0;
    #1;
    total++;
    if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
      bad++; $display("FAIL release_no_early_accept: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    total++;
    if (obs_vec() !== exp_vec() || {out_valid, odd, odd_cnt} !== {2'b11, 16'd1}) begin
      bad++; $display("FAIL release_accept: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_mode();
    test_backpressure();
    test_saturation();
    test_clr_accept();
    test_random();
    test_width1();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
